// File: rtl/countdown_timer.sv
// countdown_timer: prescaled 5-bit countdown with pause, abort, restart and a one-cycle expiry pulse.
// Define CD_AUTORELOAD_EN for periodic mode (reload from the start value on expiry, stay in RUN).
module countdown_timer #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] load_val,
   input  logic       pause,
   input  logic       abort,
   output logic [4:0] CD,
   output logic       running,
   output logic       expired,
   output logic [1:0] state
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;
   state_t st, st_n;
   logic [PW-1:0] presc, presc_n;
   logic [4:0] cd_n, reload_reg, reload_n;
   logic exp_n, cnt, tick;
   // The resume edge out of PAUSED counts like RUN, so a pause stretches the run by exactly its length.
   assign cnt = (st == RUN || st == PAUSED) && !pause;
   assign tick = cnt && presc == PMAX;
   assign state = st;
   always_comb begin
      st_n = st;
      cd_n = CD;
      presc_n = presc;
      reload_n = reload_reg;
      exp_n = 1'b0;
      if (abort) begin
         st_n = IDLE;
         cd_n = '0;
         presc_n = '0;
      end else if (start) begin
         reload_n = load_val;
         cd_n = load_val;
         presc_n = '0;
         st_n = (load_val != 5'd0) ? RUN : DONE;
         exp_n = load_val == 5'd0;
      end else if (pause) begin
         st_n = (st == RUN) ? PAUSED : st;
      end else if (tick) begin
         presc_n = '0;
         st_n = RUN;
         if (CD > 5'd1) begin
            cd_n = CD - 5'd1;
         end else begin
            exp_n = 1'b1;
`ifdef CD_AUTORELOAD_EN
            cd_n = reload_reg;
`else
            cd_n = '0;
            st_n = DONE;
`endif
         end
      end else if (cnt) begin
         st_n = RUN;
         presc_n = presc + 1'b1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= IDLE;
         CD <= '0;
         presc <= '0;
         reload_reg <= '0;
         running <= 1'b0;
         expired <= 1'b0;
      end else begin
         st <= st_n;
         CD <= cd_n;
         presc <= presc_n;
         reload_reg <= reload_n;
         running <= st_n == RUN;
         expired <= exp_n;
      end
   end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus, cycle-level reference model plus hand-computed pins.
module tb_countdown_timer;
`ifdef CD_AUTORELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   localparam int DIV = 10;
   logic clk, rst, start, pause, abort;
   logic [4:0] load_val, CD;
   logic running, expired;
   logic [1:0] state;
   int pass_cnt = 0, total = 0;
   int ms, mcd, mrel, mleft, mexp;

   countdown_timer #(.CLK_HZ(10), .TICK_HZ(1)) dut (
      .clk(clk), .rst(rst), .start(start), .load_val(load_val), .pause(pause),
      .abort(abort), .CD(CD), .running(running), .expired(expired), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Model: each edge with counting enabled consumes one of the DIV cycles before the next decrement.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ms <= 0; mcd <= 0; mrel <= 0; mleft <= DIV; mexp <= 0;
      end else begin
         mexp <= 0;
         if (abort) begin
            ms <= 0; mcd <= 0; mleft <= DIV;
         end else if (start) begin
            mcd <= load_val; mrel <= load_val; mleft <= DIV;
            ms <= (load_val != 0) ? 1 : 3;
            mexp <= (load_val == 0) ? 1 : 0;
         end else if (pause) begin
            if (ms == 1) ms <= 2;
         end else if (ms == 1 || ms == 2) begin
            ms <= 1;
            if (mleft > 1) mleft <= mleft - 1;
            else begin
               mleft <= DIV;
               if (mcd > 1) mcd <= mcd - 1;
               else begin
                  mexp <= 1;
                  if (AR) mcd <= mrel;
                  else begin
                     mcd <= 0; ms <= 3;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model_cd", CD, mcd);
         chk("model_state", state, ms);
         chk("model_running", running, (ms == 1) ? 1 : 0);
         chk("model_expired", expired, mexp);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input int lv);
      @(negedge clk);
      start = 1'b1; load_val = 5'(lv);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_abort();
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; load_val = '0;
      cyc(2);
      chk("reset_cd", CD, 0);
      chk("reset_state", state, 0);
      chk("reset_running", running, 0);
      chk("reset_expired", expired, 0);
      rst = 1'b0;
      // basic countdown from 3
      do_start(3);
      chk("basic_load_cd", CD, 3);
      chk("basic_load_state", state, 1);
      chk("basic_load_running", running, 1);
      cyc(9);  chk("basic_hold3", CD, 3);
      cyc(1);  chk("basic_cd2", CD, 2);
      cyc(10); chk("basic_cd1", CD, 1);
      cyc(10); chk("basic_end_cd", CD, AR ? 3 : 0);
      chk("basic_expired", expired, 1);
      chk("basic_end_state", state, AR ? 1 : 3);
      cyc(1);  chk("basic_expired_off", expired, 0);
      cyc(50); chk("basic_held_cd", CD, AR ? 3 : 0);
      do_abort();
      chk("abort_state", state, 0);
      // pause: 25 frozen edges starting 4 edges after start
      do_start(5);
      cyc(3); pause = 1'b1;
      cyc(1);  chk("pause_state", state, 2);
      chk("pause_running", running, 0);
      cyc(24); chk("pause_hold_cd", CD, 5);
      pause = 1'b0;
      cyc(1);  chk("pause_resume_state", state, 1);
      cyc(5);  chk("pause_pre_dec", CD, 5);
      cyc(1);  chk("pause_first_dec", CD, 4);
      cyc(39); chk("pause_cd1", CD, 1);
      cyc(1);  chk("pause_end_cd", CD, AR ? 5 : 0);
      chk("pause_end_expired", expired, 1);
      // priority
      do_start(4);
      cyc(3);
      @(negedge clk);
      start = 1'b1; abort = 1'b1; load_val = 5'd9;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("prio_abort_state", state, 0);
      chk("prio_abort_cd", CD, 0);
      @(negedge clk);
      start = 1'b1; pause = 1'b1; load_val = 5'd9;
      @(negedge clk);
      start = 1'b0;
      chk("prio_pause_state0", state, 1);
      chk("prio_pause_cd0", CD, 9);
      cyc(1);
      chk("prio_pause_state1", state, 2);
      chk("prio_pause_cd1", CD, 9);
      pause = 1'b0;
      do_abort();
      // boundaries
      do_start(0);
      chk("zero_state", state, 3);
      chk("zero_expired", expired, 1);
      chk("zero_cd", CD, 0);
      cyc(1); chk("zero_expired_off", expired, 0);
      do_start(31);
      chk("max_load", CD, 31);
      cyc(309); chk("max_cd1", CD, 1);
      cyc(1);   chk("max_end_cd", CD, AR ? 31 : 0);
      chk("max_end_expired", expired, 1);
      // restart and autoreload sequence 2,1,2,1,2
      do_start(2);
      chk("restart_cd", CD, 2);
      chk("restart_state", state, 1);
      cyc(10); chk("ar_seq1", CD, 1);
      cyc(10); chk("ar_seq2", CD, AR ? 2 : 0);
      chk("ar_seq2_state", state, AR ? 1 : 3);
      chk("ar_seq2_expired", expired, 1);
      cyc(10); chk("ar_seq3", CD, AR ? 1 : 0);
      cyc(10); chk("ar_seq4", CD, AR ? 2 : 0);
      // asynchronous reset mid-count
      do_start(7);
      cyc(5);
      chk("pre_rst_cd", CD, 7);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_cd", CD, 0);
      chk("async_rst_state", state, 0);
      chk("async_rst_running", running, 0);
      chk("async_rst_expired", expired, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc(3);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
